pcie_cfg_tlp_encoder: RTL

Root-port-side generator of Type 0/1 configuration request TLPs (CfgRd/CfgWr) on the AXI4-Stream requester-request (RQ) interface. It also owns the config_mode handshake. While a config transaction is outstanding it drives config_mode high, so pcie_cfg_tlp_decoder diverts completions to it. It then consumes the decoder's single-cycle cpl_* status pulses and returns status and read data to the enumeration controller. It retries on CRS and times out on a lost completion.

---
 rtl/pcie_cfg_pkg.sv | 55 +++++
 rtl/pcie_cfg_tlp_encoder_desc_builder.sv | 61 ++++++
 rtl/pcie_cfg_tlp_encoder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_cfg_pkg.sv
// rtl/pcie_cfg_pkg.sv - shared constants, status codes and FSM states for the config TLP encoder
//
// Purpose : request-type codes, cfg_status codes, encoder FSM state enum and
//           RQ descriptor / tuser field offsets used by pcie_cfg_tlp_encoder
//           and pcie_rq_desc_builder.
// Ports   : none (package).
package pcie_cfg_pkg;

  // RQ descriptor request types; the low two bits are {type1, wr}
  localparam logic [3:0] REQ_CFGRD0 = 4'b1000;
  localparam logic [3:0] REQ_CFGWR0 = 4'b1001;
  localparam logic [3:0] REQ_CFGRD1 = 4'b1010;
  localparam logic [3:0] REQ_CFGWR1 = 4'b1011;

  // cfg_status codes
  localparam logic [2:0] ST_SC       = 3'd0;
  localparam logic [2:0] ST_UR       = 3'd1;
  localparam logic [2:0] ST_CRS      = 3'd2;
  localparam logic [2:0] ST_CA       = 3'd4;
  localparam logic [2:0] ST_MISMATCH = 3'd5;
  localparam logic [2:0] ST_TIMEOUT  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } cfg_state_e;

  // 128-bit RQ descriptor field offsets (DW0..DW3)
  localparam int DESC_REG_LSB      = 2;    // DW0[11:2] register number
  localparam int DESC_DWCNT_LSB    = 64;   // DW2[10:0] dword count
  localparam int DESC_REQTYPE_LSB  = 75;   // DW2[14:11] request type
  localparam int DESC_REQID_LSB    = 80;   // DW2[31:16] requester id
  localparam int DESC_TAG_LSB      = 96;   // DW3[7:0] tag
  localparam int DESC_CPLID_LSB    = 104;  // DW3[23:8] completer id
  localparam int DESC_REQID_EN_BIT = 120;  // DW3[24] requester id enable

  // tuser field offsets
  localparam int TUSER_FIRST_BE_LSB = 0;
  localparam int TUSER_LAST_BE_LSB  = 4;

  function automatic logic [3:0] cfg_req_type(input logic wr, input logic type1);
    logic [3:0] rt;
    case ({type1, wr})
      2'b00:   rt = REQ_CFGRD0;
      2'b01:   rt = REQ_CFGWR0;
      2'b10:   rt = REQ_CFGRD1;
      default: rt = REQ_CFGWR1;
    endcase
    return rt;
  endfunction

endpackage

// File: rtl/pcie_cfg_tlp_encoder_desc_builder.sv
// rtl/pcie_cfg_tlp_encoder_desc_builder.sv - combinational RQ descriptor / data beat formatter
//
// Purpose : formats either the 128-bit config request descriptor (header beat)
//           or the single-DW write payload beat, plus tkeep/tlast/tuser.
// Ports   : data_beat      in  1=payload beat, 0=header beat
//           wr, type1      in  request kind
//           target_id      in  completer BDF
//           reg_num        in  DW register number
//           byte_en        in  first DW byte enables
//           wr_data        in  write payload
//           tag            in  request tag
//           tdata/tkeep/tlast/tuser  out  formatted beat
module pcie_rq_desc_builder
  import pcie_cfg_pkg::*;
#(
  parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int          AXI4_RQ_TUSER_WIDTH = 60
) (
  input  logic                           data_beat,
  input  logic                           wr,
  input  logic                           type1,
  input  logic [15:0]                    target_id,
  input  logic [9:0]                     reg_num,
  input  logic [3:0]                     byte_en,
  input  logic [31:0]                    wr_data,
  input  logic [7:0]                     tag,
  output logic [C_DATA_WIDTH-1:0]        tdata,
  output logic [KEEP_WIDTH-1:0]          tkeep,
  output logic                           tlast,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] tuser
);

  always_comb begin
    tdata = '0;
    tkeep = '0;
    tlast = 1'b0;
    tuser = '0;
    // Single-DW request: last_be must be zero
    tuser[TUSER_FIRST_BE_LSB +: 4] = byte_en;
    tuser[TUSER_LAST_BE_LSB +: 4]  = 4'b0000;
    if (data_beat) begin
      tdata[31:0] = wr_data;
      tkeep[0]    = 1'b1;
      tlast       = 1'b1;
    end else begin
      tdata[DESC_REG_LSB +: 10]     = reg_num;
      tdata[DESC_DWCNT_LSB +: 11]   = 11'd1;
      tdata[DESC_REQTYPE_LSB +: 4]  = cfg_req_type(wr, type1);
      tdata[DESC_REQID_LSB +: 16]   = REQUESTER_ID;
      tdata[DESC_TAG_LSB +: 8]      = tag;
      tdata[DESC_CPLID_LSB +: 16]   = target_id;
      tdata[DESC_REQID_EN_BIT]      = 1'b1;
      tkeep[3:0]                    = 4'hF;
      // Reads are header-only; writes continue with the payload beat
      tlast                         = ~wr;
    end
  end

endmodule

// File: rtl/pcie_cfg_tlp_encoder.sv
// rtl/pcie_cfg_tlp_encoder.sv - root-port config request TLP generator with CRS retry
//
// Purpose : accepts one config request at a time from the enumeration
//           controller, issues CfgRd/CfgWr Type 0/1 on the RQ stream, holds
//           config_mode while the completion is outstanding, and reports
//           the decoder's completion status and read data.
// Optional: define CFG_TIMEOUT_EN to enable the completion timeout
//           (TIMEOUT_CYCLES in WAIT -> status 6); otherwise WAIT never expires.
// Ports   : user_clk, reset (sync, active-high)
//           cfg_req/cfg_wr/cfg_type1/cfg_target_id/cfg_reg_num/cfg_byte_en/cfg_wr_data  in   request
//           cfg_busy/cfg_done/cfg_status/cfg_rd_data                                      out  result
//           config_mode                                                                   out  to decoder
//           s_axis_rq_*                                                                   RQ stream
//           cpl_sc/cpl_ur/cpl_crs/cpl_ca/cpl_mismatch/cpl_data                            in   decoder status
module pcie_cfg_tlp_encoder
  import pcie_cfg_pkg::*;
#(
  parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
  parameter int          AXI4_RQ_TUSER_WIDTH = 60,
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int          MAX_RETRY           = 8,
  parameter int          TIMEOUT_CYCLES      = 65535
) (
  input  logic                           user_clk,
  input  logic                           reset,
  input  logic                           cfg_req,
  input  logic                           cfg_wr,
  input  logic                           cfg_type1,
  input  logic [15:0]                    cfg_target_id,
  input  logic [9:0]                     cfg_reg_num,
  input  logic [3:0]                     cfg_byte_en,
  input  logic [31:0]                    cfg_wr_data,
  output logic                           cfg_busy,
  output logic                           cfg_done,
  output logic [2:0]                     cfg_status,
  output logic [31:0]                    cfg_rd_data,
  output logic                           config_mode,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic                           s_axis_rq_tlast,
  output logic                           s_axis_rq_tvalid,
  input  logic                           s_axis_rq_tready,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  input  logic                           cpl_sc,
  input  logic                           cpl_ur,
  input  logic                           cpl_crs,
  input  logic                           cpl_ca,
  input  logic                           cpl_mismatch,
  input  logic [31:0]                    cpl_data
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  if (C_DATA_WIDTH != 128 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pcie_cfg_tlp_encoder: C_DATA_WIDTH must be 128 and TIMEOUT_CYCLES >= 1");
  end

  cfg_state_e state_q, state_d;

  // Request shadow registers
  logic        wr_q, wr_d;
  logic        type1_q, type1_d;
  logic [15:0] target_q, target_d;
  logic [9:0]  reg_q, reg_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic [7:0]         tag_q, tag_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  status_q, status_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        cmode_q, cmode_d;

  logic [C_DATA_WIDTH-1:0]        tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]          tkeep_q, tkeep_d;
  logic                           tlast_q, tlast_d;
  logic                           tvalid_q, tvalid_d;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] tuser_q, tuser_d;

`ifdef CFG_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
`endif

  logic rq_fire;
  assign rq_fire = tvalid_q && s_axis_rq_tready;

  // Next-state and transaction bookkeeping
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    type1_d   = type1_q;
    target_d  = target_q;
    reg_d     = reg_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    tag_d     = tag_q;
    retry_d   = retry_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    status_d  = status_q;
    rd_data_d = rd_data_q;
    cmode_d   = cmode_q;
`ifdef CFG_TIMEOUT_EN
    timer_d   = timer_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          wr_d      = cfg_wr;
          type1_d   = cfg_type1;
          target_d  = cfg_target_id;
          reg_d     = cfg_reg_num;
          be_d      = cfg_byte_en;
          wdata_d   = cfg_wr_data;
          retry_d   = '0;
          busy_d    = 1'b1;
          cmode_d   = 1'b1;
          status_d  = ST_SC;
          rd_data_d = '0;
`ifdef CFG_TIMEOUT_EN
          timer_d   = '0;
`endif
          state_d   = S_HDR;
        end
      end

      S_HDR: begin
        // Tag advances on every accepted header so each issue (including
        // CRS reissues) carries a fresh tag
        if (rq_fire) begin
          tag_d   = tag_q + 8'd1;
          state_d = wr_q ? S_DATA : S_WAIT;
        end
      end

      S_DATA: begin
        if (rq_fire) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cpl_sc) begin
          status_d  = ST_SC;
          rd_data_d = wr_q ? 32'd0 : cpl_data;
          state_d   = S_DONE;
        end else if (cpl_ur) begin
          status_d = ST_UR;
          state_d  = S_DONE;
        end else if (cpl_ca) begin
          status_d = ST_CA;
          state_d  = S_DONE;
        end else if (cpl_crs) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
`ifdef CFG_TIMEOUT_EN
            timer_d = '0;
`endif
            state_d = S_HDR;
          end else begin
            status_d = ST_CRS;
            state_d  = S_DONE;
          end
        end else if (cpl_mismatch) begin
          status_d = ST_MISMATCH;
          state_d  = S_DONE;
        end
`ifdef CFG_TIMEOUT_EN
        else if (timer_q == TIMER_W'(TIMEOUT_CYCLES)) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
        // Entering DONE: pulse done and release config_mode together
        if (state_d == S_DONE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cmode_d = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic                           bld_data_beat;
  logic [C_DATA_WIDTH-1:0]        bld_tdata;
  logic [KEEP_WIDTH-1:0]          bld_tkeep;
  logic                           bld_tlast;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] bld_tuser;

  assign bld_data_beat = (state_d == S_DATA);

  // Fed from next-state values so the beat is registered in the same cycle
  // the FSM enters HDR/DATA; inputs do not change while a beat is stalled
  pcie_rq_desc_builder #(
    .REQUESTER_ID        (REQUESTER_ID),
    .C_DATA_WIDTH        (C_DATA_WIDTH),
    .KEEP_WIDTH          (KEEP_WIDTH),
    .AXI4_RQ_TUSER_WIDTH (AXI4_RQ_TUSER_WIDTH)
  ) u_desc_builder (
    .data_beat (bld_data_beat),
    .wr        (wr_d),
    .type1     (type1_d),
    .target_id (target_d),
    .reg_num   (reg_d),
    .byte_en   (be_d),
    .wr_data   (wdata_d),
    .tag       (tag_d),
    .tdata     (bld_tdata),
    .tkeep     (bld_tkeep),
    .tlast     (bld_tlast),
    .tuser     (bld_tuser)
  );

  always_comb begin
    tvalid_d = (state_d == S_HDR) || (state_d == S_DATA);
    tdata_d  = '0;
    tkeep_d  = '0;
    tlast_d  = 1'b0;
    tuser_d  = '0;
    if (tvalid_d) begin
      tdata_d = bld_tdata;
      tkeep_d = bld_tkeep;
      tlast_d = bld_tlast;
      tuser_d = bld_tuser;
    end
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      type1_q   <= 1'b0;
      target_q  <= '0;
      reg_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      retry_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= '0;
      rd_data_q <= '0;
      cmode_q   <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      tuser_q   <= '0;
`ifdef CFG_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      type1_q   <= type1_d;
      target_q  <= target_d;
      reg_q     <= reg_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      tag_q     <= tag_d;
      retry_q   <= retry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      rd_data_q <= rd_data_d;
      cmode_q   <= cmode_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      tuser_q   <= tuser_d;
`ifdef CFG_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

  assign cfg_busy         = busy_q;
  assign cfg_done         = done_q;
  assign cfg_status       = status_q;
  assign cfg_rd_data      = rd_data_q;
  assign config_mode      = cmode_q;
  assign s_axis_rq_tdata  = tdata_q;
  assign s_axis_rq_tkeep  = tkeep_q;
  assign s_axis_rq_tlast  = tlast_q;
  assign s_axis_rq_tvalid = tvalid_q;
  assign s_axis_rq_tuser  = tuser_q;

endmodule
